// File: rtl/ara_eoc_pkg.sv
// Shared types and helpers for the Ara end-of-computation monitor.
package ara_eoc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} eoc_state_e;

  localparam int unsigned TohostExitBit = 0;

  typedef logic [62:0] exit_code_t;

  function automatic logic [63:0] pack_exit(exit_code_t code);
    return {code, 1'b1};
  endfunction

endpackage

// File: rtl/ara_eoc_slot.sv
// Per-core exit slot: latches the first exiting tohost write and its code.
module ara_eoc_slot
  import ara_eoc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        capture_en,
  input  logic        clear,
  input  logic        valid,
  input  logic [63:0] data,
  output logic        capture,
  output logic        exited,
  output logic        fail,
  output exit_code_t  code
);

  // Once exited, the slot is frozen: first exit wins.
  assign capture = capture_en & valid & data[TohostExitBit] & ~exited;
  assign fail    = exited & (code != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exited <= 1'b0;
      code   <= '0;
    end else if (clear) begin
      exited <= 1'b0;
      code   <= '0;
    end else if (capture) begin
      exited <= 1'b1;
      code   <= data[63:1];
    end
  end

endmodule

// File: rtl/ara_eoc_monitor.sv
// End-of-computation monitor: per-core exit capture, success/fail/timeout
// decision and RUN-cycle runtime measurement.
module ara_eoc_monitor
  import ara_eoc_pkg::*;
#(
  parameter int unsigned NrCores       = 1,
  parameter int unsigned CntWidth      = 64,
  parameter int unsigned TimeoutCycles = 0,
  parameter bit          StopOnFail    = 1'b1,
  parameter exit_code_t  TimeoutCode   = 63'hDEAD,
  localparam int unsigned FfW          = (NrCores > 1) ? $clog2(NrCores) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         clear_i,
  input  logic [NrCores-1:0]           tohost_valid_i,
  input  logic [NrCores-1:0][63:0]     tohost_i,
  output logic                         done_o,
  output logic [63:0]                  exit_o,
  output logic                         fail_o,
  output logic                         timeout_o,
  output logic [CntWidth-1:0]          runtime_o,
  output logic [NrCores-1:0]           exited_mask_o,
  output logic [FfW-1:0]               first_fail_core_o
);

  eoc_state_e                  state;
  logic [CntWidth-1:0]         cnt, cnt_nxt;
  logic [NrCores-1:0]          capture, exited, fail_v, new_fail;
  logic [NrCores-1:0][62:0]    codes;
  logic [FfW-1:0]              ff_core, nf_idx;
  exit_code_t                  nf_code, fail_code;
  logic                        all_exit, old_fail, any_fail, stop_fail, to_hit, term;

  for (genvar c = 0; c < NrCores; c++) begin : g_slot
    ara_eoc_slot u_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .capture_en(state == RUN),
      .clear     (clear_i),
      .valid     (tohost_valid_i[c]),
      .data      (tohost_i[c]),
      .capture   (capture[c]),
      .exited    (exited[c]),
      .fail      (fail_v[c]),
      .code      (codes[c])
    );
    assign new_fail[c] = capture[c] & (tohost_i[c][63:1] != '0);
  end

  // Lowest-index failing capture this cycle; used only if no earlier failure.
  always_comb begin
    nf_idx  = '0;
    nf_code = '0;
    for (int c = NrCores - 1; c >= 0; c--) begin
      if (new_fail[c]) begin
        nf_idx  = FfW'(c);
        nf_code = tohost_i[c][63:1];
      end
    end
  end

  // The watchdog and runtime counters would always hold identical values,
  // so a single saturating counter serves both.
  assign cnt_nxt   = (&cnt) ? cnt : cnt + 1'b1;
  assign all_exit  = &(exited | capture);
  assign old_fail  = |fail_v;
  assign any_fail  = old_fail | (|new_fail);
  assign stop_fail = StopOnFail && any_fail;
  assign to_hit    = (TimeoutCycles != 0) && (cnt_nxt == CntWidth'(TimeoutCycles));
  assign term      = all_exit | stop_fail | to_hit;
  assign fail_code = old_fail ? codes[ff_core] : nf_code;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      ff_core   <= '0;
      done_o    <= 1'b0;
      exit_o    <= '0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else if (clear_i) begin
      state     <= IDLE;
      cnt       <= '0;
      ff_core   <= '0;
      done_o    <= 1'b0;
      exit_o    <= '0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          cnt <= cnt_nxt;
          if (!old_fail && (|new_fail)) ff_core <= nf_idx;
          if (term) begin
            state  <= DONE;
            done_o <= 1'b1;
            // Captures in the terminating cycle outrank the watchdog.
            if (!all_exit && !stop_fail) begin
              timeout_o <= 1'b1;
              fail_o    <= 1'b1;
              exit_o    <= pack_exit(TimeoutCode);
            end else if (any_fail) begin
              fail_o <= 1'b1;
              exit_o <= pack_exit(fail_code);
            end else begin
              exit_o <= pack_exit('0);
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign runtime_o         = cnt;
  assign exited_mask_o     = exited;
  assign first_fail_core_o = ff_core;

endmodule
